// File: rtl/mux_stream_nto1.sv
// N-to-1 registered stream multiplexer with valid/ready on every channel and a one-beat output slot.
// Define STREAM_MUX_RR_EN to build the round-robin arbiter selected by rr_mode.
module mux_stream_nto1 #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          select,
  input  logic                      rr_mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          active_ch
);

  logic             free;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] active_ch_q, active_ch_d;

  // The slot can take a beat when empty or when its current beat leaves this cycle.
  assign free = !out_valid_q || out_ready;

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] rr_grant;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_found;

  // First valid channel at or above the pointer, wrapping modulo CHANNELS.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      rr_idx = SEL_W'((32'(rr_ptr_q) + k) % CHANNELS);
      if (!rr_found && in_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = rr_idx;
      end
    end
  end

  always_comb begin
    if (rr_mode) begin
      grant       = rr_grant;
      grant_valid = rr_found;
    end else begin
      grant       = select;
      grant_valid = 32'(select) < CHANNELS;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer && rr_mode) begin
      rr_ptr_d = (32'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  logic rr_mode_unused;
  assign rr_mode_unused = rr_mode;
  assign grant          = select;
  assign grant_valid    = 32'(select) < CHANNELS;
`endif

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      in_ready[i] = grant_valid && free && rst_n && (32'(grant) == i);
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (32'(grant) == i) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    active_ch_d = active_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      active_ch_d = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      active_ch_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      active_ch_q <= active_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign active_ch = active_ch_q;

endmodule

// File: tb/tb_mux_stream_nto1.sv
// Bench for mux_stream_nto1: vector table plus hand sequences, transfers tracked in a scoreboard queue.
module tb_mux_stream_nto1;
  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [1:0]     select, active_ch;
  logic           rr_mode, out_valid, out_ready;
  logic [W-1:0]   out_data;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3, in_ready3;
  logic [1:0]     select3, active_ch3;
  logic           out_valid3, out_ready3;
  logic [W-1:0]   out_data3;

  always #5 clk = ~clk;

  mux_stream_nto1 #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .rr_mode(rr_mode), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .active_ch(active_ch)
  );

  mux_stream_nto1 #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .select(select3), .rr_mode(1'b0), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .active_ch(active_ch3)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        rr;
    logic [3:0]  iv;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_ir;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] ch;
  } beat_t;

  beat_t      sb[$];
  vec_t       vecs[10];
  vec_t       v;
  int         n_vec = 0;
  int         n_err = 0;
  logic       exp_ov;
  logic [7:0] exp_data;
  logic [1:0] exp_ch;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle; the expected in_ready pattern decides whether a beat is pushed.
  task automatic run_vec(input vec_t vv, input string name);
    beat_t b;
    logic  xfer;
    int    g;
    select    = vv.sel;
    rr_mode   = vv.rr;
    in_valid  = vv.iv;
    in_data   = vv.data;
    out_ready = vv.ordy;
    #1;
    chk({name, " in_ready"}, 32'(in_ready), 32'(vv.exp_ir));
    xfer = |(vv.exp_ir & vv.iv);
    if (xfer) begin
      g = 0;
      for (int i = 0; i < N; i++) if (vv.exp_ir[i]) g = i;
      b.data = vv.data[g*W +: W];
      b.ch   = 2'(g);
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
    if (xfer) begin
      b        = sb.pop_front();
      exp_ov   = 1'b1;
      exp_data = b.data;
      exp_ch   = b.ch;
    end else if (vv.ordy) begin
      exp_ov = 1'b0;
    end
    chk({name, " out_valid"}, 32'(out_valid), 32'(exp_ov));
    chk({name, " out_data"}, 32'(out_data), 32'(exp_data));
    chk({name, " active_ch"}, 32'(active_ch), 32'(exp_ch));
  endtask

  initial begin
    //          sel   rr    iv       data           ordy  exp_ir
    vecs[0] = '{2'd2, 1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0100};
    vecs[1] = '{2'd1, 1'b0, 4'b0010, 32'h1122A544, 1'b1, 4'b0010};
    vecs[2] = '{2'd1, 1'b0, 4'b0010, 32'h33445A66, 1'b1, 4'b0010};
    vecs[3] = '{2'd1, 1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0010};
    vecs[4] = '{2'd3, 1'b0, 4'b1000, 32'h3CABCDEF, 1'b0, 4'b1000};
    vecs[5] = '{2'd3, 1'b0, 4'b1000, 32'h77000000, 1'b0, 4'b0000};
    vecs[6] = '{2'd0, 1'b0, 4'b0001, 32'h00000011, 1'b0, 4'b0000};
    vecs[7] = '{2'd0, 1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0001};
    vecs[8] = '{2'd0, 1'b0, 4'b1111, 32'h123456C3, 1'b1, 4'b0001};
    vecs[9] = '{2'd2, 1'b0, 4'b0100, 32'hFF99EEDD, 1'b1, 4'b0100};

    exp_ov = 1'b0; exp_data = '0; exp_ch = '0;
    rst_n = 1'b0; in_valid = '1; in_data = '0; select = 2'd2; rr_mode = 1'b0; out_ready = 1'b0;
    in_valid3 = '1; in_data3 = '0; select3 = 2'd0; out_ready3 = 1'b0;

    #12;
    chk("reset in_ready", 32'(in_ready), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out_data", 32'(out_data), 32'h0);
    chk("reset active_ch", 32'(active_ch), 32'h0);
    chk("reset in_ready3", 32'(in_ready3), 32'h0);
    @(negedge clk);
    in_valid = '0; in_valid3 = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef STREAM_MUX_RR_EN
    // Pointer wraps past the idle channel 2: expect 0,1,3,0,1.
    for (int i = 0; i < 5; i++) begin
      v = '{2'd0, 1'b1, 4'b1011, 32'h44332211, 1'b1, 4'b0000};
      case (i)
        0, 3:    v.exp_ir = 4'b0001;
        1, 4:    v.exp_ir = 4'b0010;
        default: v.exp_ir = 4'b1000;
      endcase
      run_vec(v, $sformatf("rr%0d", i));
    end
`else
    v = '{2'd2, 1'b1, 4'b1011, 32'h44332211, 1'b1, 4'b0100};
    run_vec(v, "rr_ignored");
`endif

    // Out-of-range select on the 3-channel instance.
    select3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'hCCBBAA; out_ready3 = 1'b1;
    #1;
    chk("oor in_ready3", 32'(in_ready3), 32'h0);
    @(posedge clk);
    #1;
    chk("oor out_valid3", 32'(out_valid3), 32'h0);
    select3 = 2'd2;
    #1;
    chk("sel2 in_ready3", 32'(in_ready3), 32'b100);
    @(posedge clk);
    #1;
    in_valid3 = '0;
    chk("sel2 out_valid3", 32'(out_valid3), 32'h1);
    chk("sel2 out_data3", 32'(out_data3), 32'hCC);
    chk("sel2 active_ch3", 32'(active_ch3), 32'h2);

    // Reset while a beat is held under back-pressure.
    v = '{2'd0, 1'b0, 4'b0001, 32'h000000AB, 1'b1, 4'b0001};
    run_vec(v, "prefill");
    out_ready = 1'b0; in_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'h0);
    chk("midrst out_data", 32'(out_data), 32'h0);
    chk("midrst in_ready", 32'(in_ready), 32'h0);
    sb.delete();
    exp_ov = 1'b0; exp_data = '0; exp_ch = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef STREAM_MUX_RR_EN
    v = '{2'd0, 1'b1, 4'b1011, 32'h44332211, 1'b1, 4'b0001};
    run_vec(v, "rr_after_rst");
`else
    v = '{2'd1, 1'b0, 4'b0010, 32'h0000E700, 1'b1, 4'b0010};
    run_vec(v, "fixed_after_rst");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
